// File: rtl/sha2_msg_sched_stream_if.sv
// sha2_msg_sched_stream_if: block-in / W_t-out handshake bundle for the SHA-2 message scheduler
interface sha2_msg_sched_stream_if #(
    parameter int WORD_W = 32
);
    logic [16*WORD_W-1:0] block_i;
    logic                 block_v_i;
    logic                 block_ready_o;
    logic                 abort_i;
    logic [WORD_W-1:0]    wt_o;
    logic [6:0]           round_o;
    logic                 wt_v_o;
    logic                 wt_yumi_i;
    logic                 last_o;
    logic                 busy_o;

    modport master (
        output block_i, block_v_i, abort_i, wt_yumi_i,
        input  block_ready_o, wt_o, round_o, wt_v_o, last_o, busy_o
    );

    modport slave (
        input  block_i, block_v_i, abort_i, wt_yumi_i,
        output block_ready_o, wt_o, round_o, wt_v_o, last_o, busy_o
    );
endinterface

// File: rtl/sha2_msg_sched_stream.sv
// sha2_msg_sched_stream: SHA-2 W_t scheduler with a one-block pending buffer and valid/yumi output
module sha2_msg_sched_stream #(
    parameter int WORD_W = 32,
    parameter int ROUNDS = 64
) (
    input logic                    clk_i,
    input logic                    reset_n_i,
    sha2_msg_sched_stream_if.slave bus
);
    if (!((WORD_W == 32 && ROUNDS == 64) || (WORD_W == 64 && ROUNDS == 80))) begin : g_bad_cfg
        $error("sha2_msg_sched_stream: WORD_W/ROUNDS must be 32/64 or 64/80");
    end

    typedef enum logic {IDLE, RUN} state_e;

    state_e               state_q;
    // Window word j lives at win_q[15-j], so a whole block loads with word 0 at the top.
    logic [15:0][WORD_W-1:0] win_q;
    logic [16*WORD_W-1:0] pend_q;
    logic                 pend_full_q;
    logic [6:0]           round_q;
    logic                 rdy_q;
    logic [WORD_W-1:0]    w_new;
    logic                 run, accept, yumi, at_last, last_beat;

    function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int n);
        return (x >> n) | (x << (WORD_W - n));
    endfunction

    function automatic logic [WORD_W-1:0] sig0(input logic [WORD_W-1:0] x);
        return WORD_W == 32 ? rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3)
                            : rotr(x, 1) ^ rotr(x, 8) ^ (x >> 7);
    endfunction

    function automatic logic [WORD_W-1:0] sig1(input logic [WORD_W-1:0] x);
        return WORD_W == 32 ? rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10)
                            : rotr(x, 19) ^ rotr(x, 61) ^ (x >> 6);
    endfunction

    assign run       = state_q == RUN;
    assign at_last   = round_q == 7'(ROUNDS - 1);
    assign yumi      = run & bus.wt_yumi_i;
    assign last_beat = yumi & at_last;
    // Abort keeps ready high so the offered block is visibly taken and dropped.
    assign bus.block_ready_o = rdy_q & (!pend_full_q | bus.abort_i);
    assign accept    = bus.block_v_i & bus.block_ready_o & !bus.abort_i;
    assign w_new     = sig1(win_q[1]) + win_q[6] + sig0(win_q[14]) + win_q[15];

    assign bus.wt_o    = win_q[15];
    assign bus.round_o = round_q;
    assign bus.wt_v_o  = run;
    assign bus.last_o  = run & at_last;
    assign bus.busy_o  = run;

    // Scheduler FSM: load/shift window, park a second block, chain blocks without a bubble.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= IDLE;
            win_q       <= '0;
            pend_q      <= '0;
            pend_full_q <= 1'b0;
            round_q     <= '0;
            rdy_q       <= 1'b0;
        end else begin
            rdy_q <= 1'b1;
            if (bus.abort_i) begin
                state_q     <= IDLE;
                pend_full_q <= 1'b0;
                round_q     <= '0;
            end else if (state_q == IDLE) begin
                if (accept) begin
                    win_q   <= bus.block_i;
                    round_q <= '0;
                    state_q <= RUN;
                end
            end else if (last_beat) begin
                round_q <= '0;
                if (pend_full_q) begin
                    win_q       <= pend_q;
                    pend_full_q <= 1'b0;
                end else if (accept) begin
                    win_q <= bus.block_i;
                end else begin
                    state_q <= IDLE;
                end
            end else begin
                if (yumi) begin
                    win_q   <= {win_q[14:0], w_new};
                    round_q <= round_q + 7'd1;
                end
                if (accept) begin
                    pend_q      <= bus.block_i;
                    pend_full_q <= 1'b1;
                end
            end
        end
    end

    a_yumi_needs_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        bus.wt_yumi_i |-> bus.wt_v_o)
        else $error("wt_yumi_i asserted while wt_v_o is low");
endmodule

// File: tb/tb_sha2_msg_sched_stream.sv
// tb_sha2_msg_sched_stream: directed vectors and corner sequences for both SHA-2 widths
module tb_sha2_msg_sched_stream;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;

    typedef struct {
        string       name;
        bit          w64;
        int          r;
        logic [63:0] exp;
    } vec_t;

    logic [31:0] e32 [0:1][0:63];
    logic [63:0] e64 [0:79];
    logic [31:0] got32 [0:63];
    logic [63:0] got64 [0:79];

    sha2_msg_sched_stream_if #(.WORD_W(32)) b32();
    sha2_msg_sched_stream_if #(.WORD_W(64)) b64();

    sha2_msg_sched_stream #(.WORD_W(32), .ROUNDS(64)) dut32 (.clk_i(clk), .reset_n_i(reset_n), .bus(b32));
    sha2_msg_sched_stream #(.WORD_W(64), .ROUNDS(80)) dut64 (.clk_i(clk), .reset_n_i(reset_n), .bus(b64));

    always #5 clk = ~clk;

    function automatic logic [31:0] r32(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [63:0] r64(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic fill32(input int k, input logic [511:0] b);
        for (int t = 0; t < 64; t++) begin
            if (t < 16) e32[k][t] = b[511-32*t -: 32];
            else e32[k][t] = (r32(e32[k][t-2], 17) ^ r32(e32[k][t-2], 19) ^ (e32[k][t-2] >> 10))
                           + e32[k][t-7]
                           + (r32(e32[k][t-15], 7) ^ r32(e32[k][t-15], 18) ^ (e32[k][t-15] >> 3))
                           + e32[k][t-16];
        end
    endtask

    task automatic fill64(input logic [1023:0] b);
        for (int t = 0; t < 80; t++) begin
            if (t < 16) e64[t] = b[1023-64*t -: 64];
            else e64[t] = (r64(e64[t-2], 19) ^ r64(e64[t-2], 61) ^ (e64[t-2] >> 6))
                        + e64[t-7]
                        + (r64(e64[t-15], 1) ^ r64(e64[t-15], 8) ^ (e64[t-15] >> 7))
                        + e64[t-16];
        end
    endtask

    task automatic run32(input int k, input int stall_at, input int offer_at, input logic [511:0] ob,
                         input int refuse_at, input logic [511:0] rb, input int stop_at);
        int t = 0;
        int stalls = 0;
        while (t < 64) begin
            @(negedge clk);
            b32.block_v_i = 1'b0;
            if (t == stop_at) begin
                b32.wt_yumi_i = 1'b0;
                return;
            end
            chk($sformatf("wt_v r%0d", t), 64'(b32.wt_v_o), 64'd1);
            chk($sformatf("round r%0d", t), 64'(b32.round_o), 64'(t));
            chk($sformatf("wt r%0d", t), 64'(b32.wt_o), 64'(e32[k][t]));
            chk($sformatf("last r%0d", t), 64'(b32.last_o), 64'(t == 63));
            got32[t] = b32.wt_o;
            if (offer_at >= 0 && t > offer_at)
                chk($sformatf("ready_pend r%0d", t), 64'(b32.block_ready_o), 64'd0);
            if (t == offer_at) begin b32.block_i = ob; b32.block_v_i = 1'b1; end
            if (t == refuse_at) begin b32.block_i = rb; b32.block_v_i = 1'b1; end
            if (t == stall_at && stalls < 5) begin
                b32.wt_yumi_i = 1'b0;
                stalls++;
            end else begin
                b32.wt_yumi_i = 1'b1;
                t++;
            end
        end
        @(negedge clk);
        b32.wt_yumi_i = 1'b0;
        b32.block_v_i = 1'b0;
    endtask

    task automatic idle32(input string nm);
        chk({nm, "_wt_v"}, 64'(b32.wt_v_o), 64'd0);
        chk({nm, "_busy"}, 64'(b32.busy_o), 64'd0);
        chk({nm, "_last"}, 64'(b32.last_o), 64'd0);
    endtask

    task automatic offer32(input logic [511:0] b);
        chk("ready_offer", 64'(b32.block_ready_o), 64'd1);
        b32.block_i = b;
        b32.block_v_i = 1'b1;
    endtask

    initial begin
        vec_t tbl [9];
        logic [511:0] abc32, blk_b;
        logic [1023:0] abc64;
        b32.block_i = '0; b32.block_v_i = 1'b0; b32.abort_i = 1'b0; b32.wt_yumi_i = 1'b0;
        b64.block_i = '0; b64.block_v_i = 1'b0; b64.abort_i = 1'b0; b64.wt_yumi_i = 1'b0;
        abc32 = {32'h61626380, 448'd0, 32'h18};
        abc64 = {64'h6162638000000000, 896'd0, 64'h18};
        for (int i = 0; i < 16; i++) blk_b[32*i +: 32] = $urandom;
        fill32(0, abc32);
        fill32(1, blk_b);
        fill64(abc64);
        tbl[0] = '{"sha256_r0",  1'b0, 0,  64'h61626380};
        tbl[1] = '{"sha256_r1",  1'b0, 1,  64'h0};
        tbl[2] = '{"sha256_r15", 1'b0, 15, 64'h18};
        tbl[3] = '{"sha256_r16", 1'b0, 16, 64'h61626380};
        tbl[4] = '{"sha256_r17", 1'b0, 17, 64'h000F0000};
        tbl[5] = '{"sha512_r0",  1'b1, 0,  64'h6162638000000000};
        tbl[6] = '{"sha512_r15", 1'b1, 15, 64'h18};
        tbl[7] = '{"sha512_r16", 1'b1, 16, 64'h6162638000000000};
        tbl[8] = '{"sha512_r17", 1'b1, 17, 64'h00030000000000C0};

        // reset state
        #2;
        chk("rst_wt", 64'(b32.wt_o), 64'd0);
        chk("rst_round", 64'(b32.round_o), 64'd0);
        chk("rst_ready", 64'(b32.block_ready_o), 64'd0);
        chk("rst_wt64", b64.wt_o, 64'd0);
        chk("rst_ready64", 64'(b64.block_ready_o), 64'd0);
        idle32("rst");
        @(negedge clk);
        reset_n = 1'b1;
        chk("rel_ready_noclk", 64'(b32.block_ready_o), 64'd0);
        @(negedge clk);
        chk("rel_ready", 64'(b32.block_ready_o), 64'd1);

        // SHA-256 "abc", yumi every cycle
        offer32(abc32);
        run32(0, -1, -1, '0, -1, '0, -1);
        idle32("abc_done");

        // SHA-512 "abc"
        chk("ready64", 64'(b64.block_ready_o), 64'd1);
        b64.block_i = abc64;
        b64.block_v_i = 1'b1;
        for (int t = 0; t < 80; t++) begin
            @(negedge clk);
            b64.block_v_i = 1'b0;
            chk($sformatf("wt_v64 r%0d", t), 64'(b64.wt_v_o), 64'd1);
            chk($sformatf("round64 r%0d", t), 64'(b64.round_o), 64'(t));
            chk($sformatf("wt64 r%0d", t), b64.wt_o, e64[t]);
            chk($sformatf("last64 r%0d", t), 64'(b64.last_o), 64'(t == 79));
            got64[t] = b64.wt_o;
            b64.wt_yumi_i = 1'b1;
        end
        @(negedge clk);
        b64.wt_yumi_i = 1'b0;
        chk("abc64_done_wt_v", 64'(b64.wt_v_o), 64'd0);
        chk("abc64_done_busy", 64'(b64.busy_o), 64'd0);

        for (int i = 0; i < 9; i++)
            chk(tbl[i].name, tbl[i].w64 ? got64[tbl[i].r] : 64'(got32[tbl[i].r]), tbl[i].exp);

        // stall 5 cycles at round 20
        offer32(abc32);
        run32(0, 20, -1, '0, -1, '0, -1);
        idle32("stall_done");

        // back-to-back, second block at round 10, third refused at round 20
        offer32(abc32);
        run32(0, -1, 10, blk_b, 20, ~blk_b, -1);
        chk("b2b_wt_v", 64'(b32.wt_v_o), 64'd1);
        chk("b2b_round", 64'(b32.round_o), 64'd0);
        chk("b2b_wt", 64'(b32.wt_o), 64'(e32[1][0]));
        chk("b2b_ready", 64'(b32.block_ready_o), 64'd1);
        run32(1, -1, -1, '0, -1, '0, -1);
        idle32("b2b_done");

        // abort at round 30 with a pending block
        offer32(abc32);
        run32(0, -1, 28, blk_b, -1, '0, 30);
        b32.abort_i = 1'b1;
        b32.block_i = abc32;
        b32.block_v_i = 1'b1;
        #1;
        chk("abort_ready", 64'(b32.block_ready_o), 64'd1);
        @(negedge clk);
        b32.abort_i = 1'b0;
        b32.block_v_i = 1'b0;
        idle32("abort");
        chk("abort_round", 64'(b32.round_o), 64'd0);
        chk("abort_ready_after", 64'(b32.block_ready_o), 64'd1);
        @(negedge clk);
        idle32("abort_nopend");
        offer32(blk_b);
        run32(1, -1, -1, '0, -1, '0, -1);
        idle32("abort_new_done");

        // asynchronous reset mid-block at round 40
        offer32(abc32);
        run32(0, -1, -1, '0, -1, '0, 40);
        #2;
        reset_n = 1'b0;
        #1;
        idle32("arst");
        chk("arst_round", 64'(b32.round_o), 64'd0);
        chk("arst_ready", 64'(b32.block_ready_o), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("arst_rel_ready", 64'(b32.block_ready_o), 64'd1);
        idle32("arst_rel");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/sha2_msg_sched_stream.md
Name: sha2_msg_sched_stream

Overview:
Parametrised SHA-2 message scheduler. It produces the W_t stream for the compression round engine, for SHA-224/256 (32-bit words, 64 rounds) or SHA-384/512 (64-bit words, 80 rounds).
- Blocks enter through a valid/ready handshake, with a one-entry pending buffer so consecutive blocks stream with no bubble.
- W_t leaves through a valid/yumi handshake, so the compressor may stall any round.
- The block sits between the padder/block buffer and the SHA-2 compression core.

Parameters:
WORD_W, 32, word width; legal values 32 (SHA-224/256 sigma set) and 64 (SHA-384/512 sigma set); any other value is an elaboration error.
ROUNDS, 64, rounds per block; must be 64 when WORD_W=32 and 80 when WORD_W=64; elaboration error otherwise.

Ports:
clk_i  in  1  clock, rising edge
reset_n_i  in  1  asynchronous active-low reset
block_i  in  16*WORD_W  512/1024-bit message block; word 0 in the MSBs
block_v_i  in  1  block_i valid
block_ready_o  out  1  scheduler can accept a block this cycle
abort_i  in  1  synchronous flush of the current and pending blocks
wt_o  out  WORD_W  current W_t
round_o  out  7  index t of wt_o
wt_v_o  out  1  wt_o/round_o valid
wt_yumi_i  in  1  consumer takes wt_o this cycle; legal only when wt_v_o=1
last_o  out  1  wt_v_o and round_o==ROUNDS-1
busy_o  out  1  FSM in RUN

Behaviour:
- Reset (reset_n_i=0, asynchronous): FSM=IDLE, window W[0..15]=0, pending buffer empty and 0, round counter=0. Outputs: wt_o=0, round_o=0, wt_v_o=0, last_o=0, busy_o=0, block_ready_o=0 while reset is asserted, 1 from the first clock after release.
- Storage:
  - 16-word shift window; wt_o = window[0] straight from flops (zero-latency, no combinational input-to-output path).
  - One pending block register plus a pending_full flag.
- block_ready_o = !pending_full. A block is accepted on block_v_i & block_ready_o.
- Sigma functions:
  - WORD_W=32: s0 = ROTR7^ROTR18^SHR3; s1 = ROTR17^ROTR19^SHR10.
  - WORD_W=64: s0 = ROTR1^ROTR8^SHR7; s1 = ROTR19^ROTR61^SHR6.
  - All additions are modulo 2^WORD_W.
- w_new = s1(window[14]) + window[9] + s0(window[1]) + window[0]; this is W[t+16].
- FSM IDLE: wt_v_o=0. An accepted block loads straight into the window (word 0 = block_i MSBs), round=0, next state RUN. pending_full stays 0.
- FSM RUN: wt_v_o=1.
  - On wt_yumi_i: window shifts down one word, window[15] <= w_new, round increments.
  - Without wt_yumi_i: window and round hold.
  - A block accepted in RUN goes to the pending buffer; pending_full <= 1.
- Last round (wt_yumi_i with round==ROUNDS-1):
  - If pending_full: window <= pending, round <= 0, pending_full <= 0, stay RUN (no bubble).
  - Else if a block is accepted the same cycle: it bypasses into the window, round <= 0, stay RUN.
  - Else: next state IDLE, round <= 0.
- Simultaneous accept and last-round yumi with pending_full=1 cannot occur, because block_ready_o=0 then.
- W[t] for t>=16 only exists after the shift; values are not precomputed. The window needs no wrap-around of the round counter beyond ROUNDS-1.
- abort_i (highest priority after reset):
  - Next cycle: IDLE, pending_full=0, round=0.
  - Any block offered in the same cycle is dropped; block_ready_o stays 1 during abort.
  - Window contents are don't-care and may hold stale data.
- wt_yumi_i while wt_v_o=0 is ignored. An SVA assertion flags it as a protocol error.
- Reset mid-block: all state clears immediately; no partial output after release.

Test Plan:
- SHA-256 "abc" (WORD_W=32): block 0x61626380, 14×0, 0x00000018; yumi every cycle -> round 0 = 0x61626380, round 15 = 0x00000018, round 16 = 0x61626380, round 17 = 0x000F0000; exactly 64 valid beats; last_o only at round 63; busy_o drops the cycle after.
- SHA-512 "abc" (WORD_W=64, ROUNDS=80): word0 0x6162638000000000, word15 0x18 -> round 16 = 0x6162638000000000, round 17 = 0x00030000000000C0; 80 beats; last_o at round 79.
- Stall: yumi deasserted 5 cycles at round 20 -> wt_o and round_o hold constant; the stream resumes with the same value sequence as the no-stall run.
- Back-to-back: second block offered at round 10 -> accepted, block_ready_o=0 until the last beat; the round after 63 is block2 round 0 with no wt_v_o gap. A third block is refused meanwhile.
- Abort at round 30 with a pending block -> next cycle wt_v_o=0, busy_o=0, block_ready_o=1; a new block then streams from round 0 correctly.
- Async reset asserted mid-clock at round 40 -> wt_v_o=0 and round_o=0 immediately without a clock edge; block_ready_o=1 one clock after release.
